// File: rtl/dsram_axi_slave_if.sv
// AXI4-lite request/response bundle between the LSU and the data SRAM responder.
interface dsram_axi_if;
  logic [31:0] araddr_i;
  logic        arvalid_i;
  logic        arready_o;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rvalid_o;
  logic        rready_i;
  logic [31:0] awaddr_i;
  logic        awvalid_i;
  logic        awready_o;
  logic [31:0] wdata_i;
  logic [7:0]  wstrb_i;
  logic        wvalid_i;
  logic        wready_o;
  logic [1:0]  bresp_o;
  logic        bvalid_o;
  logic        bready_i;

  modport slave (
    input  araddr_i, arvalid_i, rready_i, awaddr_i, awvalid_i,
           wdata_i, wstrb_i, wvalid_i, bready_i,
    output arready_o, rdata_o, rresp_o, rvalid_o, awready_o, wready_o,
           bresp_o, bvalid_o
  );

  modport master (
    output araddr_i, arvalid_i, rready_i, awaddr_i, awvalid_i,
           wdata_i, wstrb_i, wvalid_i, bready_i,
    input  arready_o, rdata_o, rresp_o, rvalid_o, awready_o, wready_o,
           bresp_o, bvalid_o
  );
endinterface

// File: rtl/dsram_axi_slave.sv
// AXI4-lite data SRAM responder: independent read and write FSMs with
// programmable latency, byte-enabled writes and DECERR for unmapped addresses.
module dsram_axi_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          RD_LAT      = 2,
  parameter int          WR_LAT      = 1
) (
  input logic        clk,
  input logic        rst,
  dsram_axi_if.slave bus
);
  localparam int          IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN    = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  RD_LOAD = 4'(RD_LAT - 1);
  localparam logic [3:0]  WR_LOAD = 4'(WR_LAT - 1);
  localparam logic [1:0]  OKAY    = 2'b00;
  localparam logic [1:0]  DECERR  = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  logic [3:0][7:0] mem [DEPTH_WORDS];

  r_state_t    r_state_reg, r_state_next;
  logic [3:0]  r_cnt_reg, r_cnt_next;
  logic [31:0] r_addr_reg;
  logic [31:0] rdata_reg;
  logic [1:0]  rresp_reg;
  logic        ar_ready, r_valid, r_sample;
  logic [31:0] r_sample_addr;
  logic [32:0] r_off;
  logic        r_hit;
  logic [IDX_W-1:0] r_idx;

  w_state_t    w_state_reg, w_state_next;
  logic [3:0]  w_cnt_reg, w_cnt_next;
  logic        aw_got_reg, aw_got_next, w_got_reg, w_got_next;
  logic [31:0] w_addr_reg, wdata_reg;
  logic [3:0]  wstrb_reg;
  logic [1:0]  bresp_reg;
  logic        aw_ready, w_ready, b_valid, w_commit;
  logic [32:0] w_off;
  logic        w_hit;
  logic [IDX_W-1:0] w_idx;
  logic        unused_bits;

  // With a one-cycle read latency the sample happens on the handshake edge itself.
  assign r_sample_addr = (r_state_reg == R_IDLE) ? bus.araddr_i : r_addr_reg;
  // 33-bit offset: a negative result (bit 32) marks addresses below BASE_ADDR.
  assign r_off = {1'b0, r_sample_addr} - {1'b0, BASE_ADDR};
  assign r_hit = !r_off[32] && (r_off < SPAN);
  assign r_idx = r_off[IDX_W+1:2];
  assign w_off = {1'b0, w_addr_reg} - {1'b0, BASE_ADDR};
  assign w_hit = !w_off[32] && (w_off < SPAN);
  assign w_idx = w_off[IDX_W+1:2];
  assign unused_bits = ^bus.wstrb_i[7:4];

  always_comb begin
    r_state_next = r_state_reg;
    r_cnt_next   = r_cnt_reg;
    ar_ready     = 1'b0;
    r_valid      = 1'b0;
    r_sample     = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        ar_ready = 1'b1;
        if (bus.arvalid_i) begin
          r_cnt_next = RD_LOAD;
          if (RD_LOAD == 4'd0) begin
            r_sample     = 1'b1;
            r_state_next = R_RESP;
          end else begin
            r_state_next = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        r_cnt_next = r_cnt_reg - 4'd1;
        if (r_cnt_reg <= 4'd1) begin
          r_sample     = 1'b1;
          r_state_next = R_RESP;
        end
      end
      R_RESP: begin
        r_valid = 1'b1;
        if (bus.rready_i) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_next = w_state_reg;
    w_cnt_next   = w_cnt_reg;
    aw_got_next  = aw_got_reg;
    w_got_next   = w_got_reg;
    aw_ready     = 1'b0;
    w_ready      = 1'b0;
    b_valid      = 1'b0;
    w_commit     = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        aw_ready = !aw_got_reg;
        w_ready  = !w_got_reg;
        if (aw_ready && bus.awvalid_i) aw_got_next = 1'b1;
        if (w_ready && bus.wvalid_i)   w_got_next  = 1'b1;
        if (aw_got_next && w_got_next) begin
          aw_got_next  = 1'b0;
          w_got_next   = 1'b0;
          w_cnt_next   = WR_LOAD;
          w_state_next = W_WAIT;
        end
      end
      W_WAIT: begin
        if (w_cnt_reg == 4'd0) begin
          w_commit     = 1'b1;
          w_state_next = W_RESP;
        end else begin
          w_cnt_next = w_cnt_reg - 4'd1;
        end
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (bus.bready_i) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_reg <= R_IDLE;
      r_cnt_reg   <= 4'd0;
      rdata_reg   <= 32'd0;
      rresp_reg   <= OKAY;
      w_state_reg <= W_IDLE;
      w_cnt_reg   <= 4'd0;
      aw_got_reg  <= 1'b0;
      w_got_reg   <= 1'b0;
      bresp_reg   <= OKAY;
    end else begin
      r_state_reg <= r_state_next;
      r_cnt_reg   <= r_cnt_next;
      w_state_reg <= w_state_next;
      w_cnt_reg   <= w_cnt_next;
      aw_got_reg  <= aw_got_next;
      w_got_reg   <= w_got_next;
      if (r_sample) begin
        rdata_reg <= r_hit ? mem[r_idx] : 32'd0;
        rresp_reg <= r_hit ? OKAY : DECERR;
      end
      if (w_commit) bresp_reg <= w_hit ? OKAY : DECERR;
    end
  end

  // Request latches and SRAM array carry no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (ar_ready && bus.arvalid_i) r_addr_reg <= bus.araddr_i;
    if (aw_ready && bus.awvalid_i) w_addr_reg <= bus.awaddr_i;
    if (w_ready && bus.wvalid_i) begin
      wdata_reg <= bus.wdata_i;
      wstrb_reg <= bus.wstrb_i[3:0];
    end
    if (!rst && w_commit && w_hit) begin
      for (int k = 0; k < 4; k++) begin
        if (wstrb_reg[k]) mem[w_idx][k] <= wdata_reg[8*k +: 8];
      end
    end
  end

  assign bus.arready_o = !rst && ar_ready;
  assign bus.rvalid_o  = !rst && r_valid;
  assign bus.rdata_o   = rst ? 32'd0 : rdata_reg;
  assign bus.rresp_o   = rst ? 2'b00 : rresp_reg;
  assign bus.awready_o = !rst && aw_ready;
  assign bus.wready_o  = !rst && w_ready;
  assign bus.bvalid_o  = !rst && b_valid;
  assign bus.bresp_o   = rst ? 2'b00 : bresp_reg;
endmodule
